// File: rtl/tester_common_pkg.sv
`timescale 1ns/1ps
// tester_common: types and constants shared by the speed-test blocks.
//   port_config_t     : per-port test settings handed out by the controller
//   gen_state_t       : frame generator FSM states
//   clamp_frame_len() : limits a requested frame length to the legal range
//   last_beat_index() : index of the final 64-bit beat for a given length
package tester_common;

  localparam logic [15:0] TEST_ETHERTYPE = 16'h88B5;
  localparam int          MIN_FRAME_LEN  = 60;
  localparam int          MAX_FRAME_LEN  = 1514;

  // Bytes 0..19 hold the fixed header; payload starts at byte 20.
  localparam int          HDR_BYTES      = 20;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] frame_len;
    logic [31:0] frame_count;
    logic [15:0] gap_cycles;
  } port_config_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } gen_state_t;

  // 11 bits are enough for the clamped length (max 1514).
  function automatic logic [10:0] clamp_frame_len(input logic [15:0] len);
    if (len < 16'(MIN_FRAME_LEN)) return 11'(MIN_FRAME_LEN);
    if (len > 16'(MAX_FRAME_LEN)) return 11'(MAX_FRAME_LEN);
    return len[10:0];
  endfunction

  // ceil(len/8) - 1; at most 189 for a 1514-byte frame.
  function automatic logic [7:0] last_beat_index(input logic [10:0] len);
    logic [10:0] rounded;
    rounded = len + 11'd7;
    return rounded[10:3] - 8'd1;
  endfunction

endpackage

// File: rtl/speed_test_beat_builder.sv
`timescale 1ns/1ps
// speed_test_beat_builder: purely combinational mapping from the current beat
// index plus the latched test settings to one 64-bit AXIS beat.
//   beat_idx  : beat number within the current frame (0 = first)
//   frame_len : clamped frame length in bytes, FCS excluded
//   dst_mac   : destination MAC, sent MSB first at byte 0
//   src_mac   : source MAC, sent MSB first at byte 6
//   seq_num   : frame sequence number, big-endian at bytes 14..17
//   tdata     : beat data, byte 0 of the beat in bits [7:0]
//   tkeep     : byte enables (partial only on the last beat)
//   tlast     : high on the final beat of the frame
module speed_test_beat_builder
  import tester_common::*;
#(
  parameter logic [7:0] PORT_ID = 8'd0
) (
  input  logic [7:0]  beat_idx,
  input  logic [10:0] frame_len,
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
  input  logic [31:0] seq_num,
  output logic [63:0] tdata,
  output logic [7:0]  tkeep,
  output logic        tlast
);

  logic [HDR_BYTES*8-1:0] header;
  logic [7:0]             hdr_bytes [32];
  logic [7:0]             last_idx;
  logic [10:0]            byte_idx;

  // Header laid out MSB-first so that byte 0 sits in the top octet.
  assign header   = {dst_mac, src_mac, TEST_ETHERTYPE, seq_num, PORT_ID, 8'h00};
  assign last_idx = last_beat_index(frame_len);
  assign tlast    = (beat_idx == last_idx);

  // Table sized to a power of two so a 5-bit index never falls off the end.
  always_comb begin
    for (int k = 0; k < 32; k++) hdr_bytes[k] = 8'h00;
    for (int k = 0; k < HDR_BYTES; k++) begin
      hdr_bytes[k] = header[(HDR_BYTES-1-k)*8 +: 8];
    end
  end

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    tdata    = '0;
    tkeep    = '0;
    byte_idx = '0;
    for (int b = 0; b < 8; b++) begin
      byte_idx = {beat_idx, 3'(b)};
      // Lanes past the frame end stay disabled and zero; this also yields the
      // (1<<(len%8))-1 pattern on the last beat and 8'hFF everywhere else.
      if (byte_idx < frame_len) begin
        tkeep[b]       = 1'b1;
        tdata[b*8 +: 8] = (byte_idx < 11'(HDR_BYTES)) ? hdr_bytes[byte_idx[4:0]]
                                                      : byte_idx[7:0];
      end
    end
  end

endmodule

// File: rtl/speed_test_frame_gen.sv
`timescale 1ns/1ps
// speed_test_frame_gen: per-port test traffic source. Accepts start/stop pulses
// and a port_config_t from the speed-test controller and streams numbered test
// Ethernet frames over a 64-bit AXI-Stream master toward the TX MAC.
//   clk, rst       : clock, synchronous active-high reset
//   start, stop    : single-cycle control pulses from the controller
//   port_config    : test settings, captured when start is accepted
//   gen_ready      : high while idle and able to accept start
//   m_axis_*       : AXI-Stream master (tdata/tkeep/tlast/tvalid, tready in)
//   frames_sent    : frames completed in the current or most recent test
module speed_test_frame_gen
  import tester_common::*;
#(
  parameter int         DATA_WIDTH = 64,
  parameter logic [7:0] PORT_ID    = 8'd0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  port_config_t            port_config,
  output logic                    gen_ready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [31:0]             frames_sent
);

  gen_state_t  state_q, state_d;

  // Settings latched at start; the controller may change port_config freely
  // while a test runs.
  logic [47:0] dst_mac_q;
  logic [47:0] src_mac_q;
  logic [10:0] frame_len_q;
  logic [31:0] frame_count_q;
  logic [15:0] gap_cycles_q;

  logic [7:0]  beat_idx_q;
  logic [15:0] gap_cnt_q;
  logic        stop_pending_q;

  // The sequence number of a frame always equals the number of frames already
  // completed, so a single counter serves both purposes.
  logic [31:0] frames_sent_q;

  logic [63:0] bb_tdata;
  logic [7:0]  bb_tkeep;
  logic        bb_tlast;

  logic        start_ok;
  logic        beat_fire;
  logic        frame_done;
  logic        stop_seen;
  logic        count_reached;

  speed_test_beat_builder #(
    .PORT_ID (PORT_ID)
  ) u_beat_builder (
    .beat_idx  (beat_idx_q),
    .frame_len (frame_len_q),
    .dst_mac   (dst_mac_q),
    .src_mac   (src_mac_q),
    .seq_num   (frames_sent_q),
    .tdata     (bb_tdata),
    .tkeep     (bb_tkeep),
    .tlast     (bb_tlast)
  );

  // A simultaneous stop vetoes start, so the block stays idle.
  assign start_ok      = (state_q == ST_IDLE) && start && !stop;
  assign beat_fire     = (state_q == ST_SEND) && m_axis_tready;
  assign frame_done    = beat_fire && bb_tlast;
  // A stop arriving on the boundary cycle itself counts as pending.
  assign stop_seen     = stop_pending_q || stop;
  assign count_reached = (frame_count_q != 32'd0) &&
                         ((frames_sent_q + 32'd1) == frame_count_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) state_d = ST_SEND;
      end
      ST_SEND: begin
        if (frame_done) begin
          if (stop_seen || count_reached) state_d = ST_IDLE;
          else if (gap_cycles_q != 16'd0) state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (stop_seen)                  state_d = ST_IDLE;
        else if (gap_cnt_q == 16'd1)    state_d = ST_SEND;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      dst_mac_q      <= '0;
      src_mac_q      <= '0;
      frame_len_q    <= 11'(MIN_FRAME_LEN);
      frame_count_q  <= '0;
      gap_cycles_q   <= '0;
      beat_idx_q     <= '0;
      gap_cnt_q      <= '0;
      stop_pending_q <= 1'b0;
      frames_sent_q  <= '0;
    end else begin
      state_q <= state_d;

      if (start_ok) begin
        dst_mac_q     <= port_config.dst_mac;
        src_mac_q     <= port_config.src_mac;
        frame_len_q   <= clamp_frame_len(port_config.frame_len);
        frame_count_q <= port_config.frame_count;
        gap_cycles_q  <= port_config.gap_cycles;
        beat_idx_q    <= '0;
        frames_sent_q <= '0;
      end

      if (beat_fire) begin
        beat_idx_q <= bb_tlast ? 8'd0 : beat_idx_q + 8'd1;
      end

      if (frame_done) begin
        frames_sent_q <= frames_sent_q + 32'd1;
        gap_cnt_q     <= gap_cycles_q;
      end else if (state_q == ST_GAP) begin
        gap_cnt_q <= gap_cnt_q - 16'd1;
      end

      // Sticky until the block is back in IDLE; ignored while idle.
      if (state_d == ST_IDLE)                stop_pending_q <= 1'b0;
      else if (stop && state_q != ST_IDLE)   stop_pending_q <= 1'b1;
    end
  end

  // Beat content is derived only from registers that move on a handshake, so
  // it is inherently stable while the sink stalls.
  assign m_axis_tvalid = (state_q == ST_SEND);
  assign m_axis_tdata  = m_axis_tvalid ? bb_tdata : '0;
  assign m_axis_tkeep  = m_axis_tvalid ? bb_tkeep : '0;
  assign m_axis_tlast  = m_axis_tvalid && bb_tlast;
  assign gen_ready     = (state_q == ST_IDLE);
  assign frames_sent   = frames_sent_q;

endmodule

// File: tb/tb_speed_test_frame_gen.sv
`timescale 1ns/1ps
// Self-checking bench for speed_test_frame_gen. Expected beats are generated
// by a byte-level frame model and queued when a test starts; a monitor pops
// and compares them on every AXIS handshake.
module tb_speed_test_frame_gen;
  import tester_common::*;

  localparam logic [7:0] PORT_ID = 8'h5A;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         stop;
  port_config_t cfg;
  logic         gen_ready;
  logic [63:0]  tdata;
  logic [7:0]   tkeep;
  logic         tlast;
  logic         tvalid;
  logic         tready;
  logic [31:0]  frames_sent;

  speed_test_frame_gen #(
    .DATA_WIDTH (64),
    .PORT_ID    (PORT_ID)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stop          (stop),
    .port_config   (cfg),
    .gen_ready     (gen_ready),
    .m_axis_tdata  (tdata),
    .m_axis_tkeep  (tkeep),
    .m_axis_tlast  (tlast),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .frames_sent   (frames_sent)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  beat_t sb_q[$];
  int    checks = 0;
  int    errors = 0;

  // Monitor statistics
  int          frames_seen   = 0;
  int          beats_seen    = 0;
  int          beat_in_frame = 0;
  int          idle_run      = 0;
  int          stall_cycles  = 0;
  bit          in_frame      = 0;
  bit          have_prev     = 0;
  int          gaps_q[$];
  bit          prev_stall    = 0;
  logic [63:0] prev_data;
  logic [7:0]  prev_keep;
  logic        prev_last;

  // ---------------- reference model ----------------
  function automatic int model_len(input int l);
    if (l < 60)   return 60;
    if (l > 1514) return 1514;
    return l;
  endfunction

  function automatic logic [7:0] exp_byte(input int i, input port_config_t c,
                                          input logic [31:0] seq);
    logic [47:0] m;
    logic [31:0] s;
    if (i < 6)  begin m = c.dst_mac >> (8 * (5 - i));  return m[7:0]; end
    if (i < 12) begin m = c.src_mac >> (8 * (11 - i)); return m[7:0]; end
    if (i == 12) return 8'h88;
    if (i == 13) return 8'hB5;
    if (i < 18) begin s = seq >> (8 * (17 - i)); return s[7:0]; end
    if (i == 18) return PORT_ID;
    if (i == 19) return 8'h00;
    return 8'(i);
  endfunction

  task automatic push_frame(input port_config_t c, input logic [31:0] seq);
    int    len;
    int    nb;
    beat_t b;
    len = model_len(int'(c.frame_len));
    nb  = (len + 7) / 8;
    for (int k = 0; k < nb; k++) begin
      b.data = '0;
      b.keep = '0;
      for (int l = 0; l < 8; l++) begin
        if (k * 8 + l < len) begin
          b.keep[l]        = 1'b1;
          b.data[l*8 +: 8] = exp_byte(k * 8 + l, c, seq);
        end
      end
      b.last = (k == nb - 1);
      sb_q.push_back(b);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      in_frame   = 0;
      prev_stall = 0;
    end else begin
      if (in_frame) begin
        checks++;
        if (tvalid !== 1'b1) begin
          errors++;
          $display("FAIL no_bubble: tvalid=%b inside frame %0d, required 1", tvalid, frames_seen);
        end
      end
      if (tvalid === 1'b1) begin
        if (prev_stall) begin
          checks++;
          if (tdata !== prev_data || tkeep !== prev_keep || tlast !== prev_last) begin
            errors++;
            $display("FAIL stall_stable: got %h/%h/%b, required %h/%h/%b",
                     tdata, tkeep, tlast, prev_data, prev_keep, prev_last);
          end
        end
        if (!in_frame) begin
          gaps_q.push_back(have_prev ? idle_run : -1);
          in_frame      = 1;
          beat_in_frame = 0;
        end
        if (tready === 1'b1) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got %h keep %h last %b, required no beat",
                     tdata, tkeep, tlast);
          end else begin
            beat_t       e;
            logic [63:0] m;
            e = sb_q.pop_front();
            for (int l = 0; l < 8; l++) m[l*8 +: 8] = {8{e.keep[l]}};
            if ((tdata & m) !== e.data || tkeep !== e.keep || tlast !== e.last) begin
              errors++;
              $display("FAIL beat f%0d b%0d: got %h/%h/%b, required %h/%h/%b",
                       frames_seen, beat_in_frame, tdata & m, tkeep, tlast,
                       e.data, e.keep, e.last);
            end
          end
          beats_seen++;
          beat_in_frame++;
          if (tlast === 1'b1) begin
            frames_seen++;
            in_frame  = 0;
            have_prev = 1;
            idle_run  = 0;
          end
        end else begin
          stall_cycles++;
        end
        prev_stall = (tready !== 1'b1);
        prev_data  = tdata;
        prev_keep  = tkeep;
        prev_last  = tlast;
      end else begin
        if (!in_frame) idle_run++;
        prev_stall = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_stats();
    frames_seen  = 0;
    beats_seen   = 0;
    stall_cycles = 0;
    have_prev    = 0;
    idle_run     = 0;
    gaps_q.delete();
  endtask

  task automatic pulse_start(input port_config_t c);
    @(posedge clk); #1;
    cfg   = c;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(posedge clk); #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
  endtask

  // Waits until the generator is idle with every expected beat consumed.
  task automatic wait_done(input int budget, input bit rand_ready, output bit ok);
    ok = 0;
    for (int n = 0; n < budget; n++) begin
      @(posedge clk); #1;
      if (rand_ready) tready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (gen_ready === 1'b1 && sb_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    tready = 1'b1;
  endtask

  // Waits for a given beat of a given frame; ok=0 if it never comes.
  task automatic wait_beat(input int frame, input int beat, input int budget, output bit ok);
    ok = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (frames_seen == frame && beat_in_frame == beat && in_frame) begin
        ok = 1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; tready = 1'b1; cfg = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (gen_ready !== 1'b1) begin errors++; $display("FAIL reset_gen_ready: got %b required 1", gen_ready); end
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b required 0", tvalid); end
    checks++; if (tdata !== 64'd0) begin errors++; $display("FAIL reset_tdata: got %h required 0", tdata); end
    checks++; if (tkeep !== 8'd0) begin errors++; $display("FAIL reset_tkeep: got %h required 0", tkeep); end
    checks++; if (tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b required 0", tlast); end
    checks++; if (frames_sent !== 32'd0) begin errors++; $display("FAIL reset_frames_sent: got %0d required 0", frames_sent); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (tvalid !== 1'b0 || gen_ready !== 1'b1) begin errors++; $display("FAIL post_reset_idle: tvalid %b gen_ready %b required 0/1", tvalid, gen_ready); end
  endtask

  task automatic test_basic();
    port_config_t c;
    bit ok;
    c = '{dst_mac: 48'h0011_2233_4455, src_mac: 48'hA0B1_C2D3_E4F5,
          frame_len: 16'd60, frame_count: 32'd3, gap_cycles: 16'd0};
    clear_stats();
    for (int s = 0; s < 3; s++) push_frame(c, 32'(s));
    pulse_start(c);
    checks++; if (gen_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_drop: got %b required 0", gen_ready); end
    wait_done(500, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_done: timed out, %0d beats left", sb_q.size()); end
    checks++; if (frames_seen != 3) begin errors++; $display("FAIL basic_frames_seen: got %0d required 3", frames_seen); end
    checks++; if (beats_seen != 24) begin errors++; $display("FAIL basic_beats: got %0d required 24", beats_seen); end
    checks++; if (frames_sent !== 32'd3) begin errors++; $display("FAIL basic_frames_sent: got %0d required 3", frames_sent); end
    checks++; if (gaps_q.size() != 3 || gaps_q[1] != 0 || gaps_q[2] != 0) begin
      errors++; $display("FAIL basic_no_gap: %0d frames, gaps %0d %0d required 0 0",
                         gaps_q.size(), gaps_q.size() > 1 ? gaps_q[1] : -1, gaps_q.size() > 2 ? gaps_q[2] : -1);
    end
  endtask

  task automatic test_gap();
    port_config_t c;
    bit ok;
    c = '{dst_mac: 48'hFFFF_FFFF_FFFF, src_mac: 48'h0200_0000_0001,
          frame_len: 16'd64, frame_count: 32'd2, gap_cycles: 16'd5};
    clear_stats();
    for (int s = 0; s < 2; s++) push_frame(c, 32'(s));
    pulse_start(c);
    wait_done(500, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL gap_done: timed out, %0d beats left", sb_q.size()); end
    checks++; if (gaps_q.size() != 2 || gaps_q[1] != 5) begin
      errors++; $display("FAIL gap_len: %0d frames, gap %0d required 5",
                         gaps_q.size(), gaps_q.size() > 1 ? gaps_q[1] : -1);
    end
    checks++; if (frames_sent !== 32'd2) begin errors++; $display("FAIL gap_frames_sent: got %0d required 2", frames_sent); end

    // stop while waiting out the gap ends the test without another frame
    c.frame_count = 32'd0;
    c.gap_cycles  = 16'd10;
    c.frame_len   = 16'd60;
    clear_stats();
    push_frame(c, 32'd0);
    pulse_start(c);
    wait_beat(0, 7, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL gap_stop_wait: last beat of frame 0 not seen"); end
    @(posedge clk);
    pulse_stop();
    wait_done(100, 0, ok);
    checks++; if (!ok || frames_sent !== 32'd1) begin
      errors++; $display("FAIL gap_stop: done %b frames_sent %0d required 1/1", ok, frames_sent);
    end
  endtask

  task automatic test_stall();
    port_config_t c;
    bit ok;
    c = '{dst_mac: 48'h1234_5678_9ABC, src_mac: 48'hDEAD_BEEF_CAFE,
          frame_len: 16'd1514, frame_count: 32'd4, gap_cycles: 16'd0};
    clear_stats();
    for (int s = 0; s < 4; s++) push_frame(c, 32'(s));
    pulse_start(c);
    wait_done(8000, 1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_done: timed out, %0d beats left", sb_q.size()); end
    checks++; if (beats_seen != 760) begin errors++; $display("FAIL stall_beats: got %0d required 760", beats_seen); end
    checks++; if (frames_sent !== 32'd4) begin errors++; $display("FAIL stall_frames_sent: got %0d required 4", frames_sent); end
    checks++; if (stall_cycles == 0) begin errors++; $display("FAIL stall_exercised: got 0 stalled cycles required >0"); end
  endtask

  task automatic test_stop();
    port_config_t c;
    bit ok;
    c = '{dst_mac: 48'h0A0B_0C0D_0E0F, src_mac: 48'h1011_1213_1415,
          frame_len: 16'd60, frame_count: 32'd0, gap_cycles: 16'd0};
    clear_stats();
    for (int s = 0; s < 8; s++) push_frame(c, 32'(s));
    pulse_start(c);
    wait_beat(7, 3, 500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stop_wait: beat 3 of frame 7 not seen"); end
    pulse_stop();
    wait_done(200, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stop_done: timed out, %0d beats left", sb_q.size()); end
    checks++; if (frames_seen != 8 || frames_sent !== 32'd8) begin
      errors++; $display("FAIL stop_frames: seen %0d sent %0d required 8/8", frames_seen, frames_sent);
    end
    // restart numbers frames from zero again
    c.frame_count = 32'd1;
    clear_stats();
    sb_q.delete();
    push_frame(c, 32'd0);
    pulse_start(c);
    wait_done(200, 0, ok);
    checks++; if (!ok || frames_sent !== 32'd1) begin
      errors++; $display("FAIL stop_restart: done %b frames_sent %0d required 1/1", ok, frames_sent);
    end
  endtask

  task automatic test_clamp();
    port_config_t c;
    bit ok;
    c = '{dst_mac: 48'h0000_0000_00AA, src_mac: 48'h0000_0000_00BB,
          frame_len: 16'd20, frame_count: 32'd1, gap_cycles: 16'd0};
    clear_stats();
    push_frame(c, 32'd0);
    pulse_start(c);
    wait_done(200, 0, ok);
    checks++; if (!ok || beats_seen != 8) begin errors++; $display("FAIL clamp_min: done %b beats %0d required 1/8", ok, beats_seen); end
    c.frame_len = 16'd2000;
    clear_stats();
    push_frame(c, 32'd0);
    pulse_start(c);
    wait_done(500, 0, ok);
    checks++; if (!ok || beats_seen != 190) begin errors++; $display("FAIL clamp_max: done %b beats %0d required 1/190", ok, beats_seen); end
  endtask

  task automatic test_edges();
    port_config_t c, c2;
    bit ok;
    int valid_seen;
    c = '{dst_mac: 48'h0102_0304_0506, src_mac: 48'h0708_090A_0B0C,
          frame_len: 16'd60, frame_count: 32'd2, gap_cycles: 16'd0};

    // start and stop together in IDLE: nothing happens
    @(posedge clk); #1;
    cfg = c; start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    valid_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (tvalid !== 1'b0 || gen_ready !== 1'b1) valid_seen++;
    end
    checks++; if (valid_seen != 0) begin errors++; $display("FAIL start_stop_idle: %0d active cycles required 0", valid_seen); end

    // lone stop in IDLE must not linger into the next test
    pulse_stop();
    clear_stats();
    for (int s = 0; s < 2; s++) push_frame(c, 32'(s));
    pulse_start(c);
    // second start during SEND with different settings is ignored
    c2 = c;
    c2.frame_len   = 16'd100;
    c2.frame_count = 32'd5;
    @(negedge clk);
    checks++; if (gen_ready !== 1'b0) begin errors++; $display("FAIL send_not_ready: got %b required 0", gen_ready); end
    pulse_start(c2);
    wait_done(300, 0, ok);
    checks++; if (!ok || frames_sent !== 32'd2) begin
      errors++; $display("FAIL ignored_start: done %b frames_sent %0d required 1/2", ok, frames_sent);
    end

    // reset in the middle of frame 2
    c.frame_len   = 16'd200;
    c.frame_count = 32'd0;
    clear_stats();
    for (int s = 0; s < 4; s++) push_frame(c, 32'(s));
    pulse_start(c);
    wait_beat(2, 5, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_mid_wait: beat 5 of frame 2 not seen"); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_tvalid: got %b required 0", tvalid); end
    checks++; if (frames_sent !== 32'd0) begin errors++; $display("FAIL rst_mid_frames_sent: got %0d required 0", frames_sent); end
    checks++; if (gen_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_gen_ready: got %b required 1", gen_ready); end
    rst = 1'b0;
    sb_q.delete();
    valid_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (tvalid !== 1'b0) valid_seen++;
    end
    checks++; if (valid_seen != 0) begin errors++; $display("FAIL rst_mid_quiet: %0d valid cycles required 0", valid_seen); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_stall();
    test_stop();
    test_clamp();
    test_edges();
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL leftover_beats: got %0d required 0", sb_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/speed_test_frame_gen.md
Name: speed_test_frame_gen

Overview:
- Per-port traffic source directly downstream of the speed-test controller.
- Consumes the controller's start/stop pulses and port_config_t for one port, and reports readiness back through gen_ready.
- Emits back-to-back test Ethernet frames on a 64-bit AXI-Stream master toward the port's TX MAC.
- Each frame carries a sequence number so the frame checker can detect loss and reordering.

Parameters:
- DATA_WIDTH, 64, AXIS data width in bits; only 64 is supported.
- PORT_ID, 0, 8-bit port index written into every frame.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse from the controller that begins a test.
- stop  in  1  single-cycle pulse from the controller that ends a test at the next frame boundary.
- port_config  in  port_config_t  per-port test settings; sampled only when start is accepted.
- gen_ready  out  1  high while idle and able to accept start.
- m_axis_tdata  out  64  frame data; byte 0 is in bits [7:0].
- m_axis_tkeep  out  8  byte enables.
- m_axis_tlast  out  1  marks the last beat of a frame.
- m_axis_tvalid  out  1  AXIS valid.
- m_axis_tready  in  1  AXIS ready.
- frames_sent  out  32  count of completed frames in the current or last test.

Behaviour:
- Reset values:
  - gen_ready=1; m_axis_tvalid=0; tdata, tkeep, tlast all 0.
  - frames_sent=0; state IDLE.
- States:
  - IDLE -> SEND on start while IDLE; the cycle start is accepted: latch port_config, clear frames_sent and the sequence counter, drop gen_ready on the next cycle.
  - SEND emits beats. On the tlast handshake: increment frames_sent and the sequence counter.
    - If stop is pending, or the latched frame_count is nonzero and reached, go to IDLE.
    - Else if gap_cycles>0, go to GAP.
    - Else stay in SEND and start the next frame on the next cycle.
  - GAP holds tvalid=0 for exactly gap_cycles cycles, then goes to SEND.
    - A stop arriving during GAP goes to IDLE on the next cycle.
- Frame length: len = port_config.frame_len clamped to [60,1514] bytes, FCS excluded.
  - Beats = ceil(len/8).
  - Last-beat tkeep = (1<<(len%8))-1, or 8'hFF when len%8==0. All other beats: 8'hFF.
- Frame layout, byte offsets:
  - 0-5 dst_mac; 6-11 src_mac; 12-13 ethertype 16'h88B5.
  - 14-17 sequence number, big-endian; 18 PORT_ID; 19 reserved 0.
  - Byte i>=20 carries i[7:0].
  - MACs are transmitted big-endian (MSB first).
- AXIS rules:
  - Once tvalid is high, tdata/tkeep/tlast stay stable until tready.
  - No tvalid bubbles inside a frame.
  - The first beat of a frame may be presented the cycle after entering SEND.
- stop handling:
  - stop while not IDLE sets a sticky stop_pending flag, which clears on entering IDLE.
  - A stop in the middle of a frame never truncates the frame.
  - stop in IDLE is ignored.
  - start outside IDLE is ignored.
  - start and stop in the same IDLE cycle: stop wins and the block stays IDLE.
- frame_count: 0 means unlimited, running until stop. The counter wraps modulo 2^32. The sequence number equals frames_sent at frame start.
- frames_sent holds its value in IDLE until the next accepted start.
- Reset mid-frame: tvalid drops the next cycle and the frame is truncated. This is acceptable because the MAC and checker share the reset.

Decomposition:
- tester_common package:
  - port_config_t fields: dst_mac[47:0], src_mac[47:0], frame_len[15:0], frame_count[31:0], gap_cycles[15:0].
  - Constants TEST_ETHERTYPE=16'h88B5, MIN_FRAME_LEN=60, MAX_FRAME_LEN=1514.
- One natural sub-module, speed_test_beat_builder: combinational mapping of (beat index, latched config, sequence number) to tdata/tkeep/tlast. The FSM and counters stay in the top module.

Test Plan:
- Config len=60, count=3, gap=0, tready=1; pulse start:
  - 3 frames of 8 beats each; last tkeep=8'h0F.
  - Sequence numbers 0,1,2; frames_sent=3; gen_ready returns high; no gaps between frames.
- len=64, count=2, gap=5: last tkeep=8'hFF; exactly 5 idle cycles between frames.
- tready toggled randomly, count=4, len=1514:
  - 190 beats per frame; data stable while stalled.
  - Payload byte i==i[7:0]; frames_sent=4.
- count=0; stop asserted on beat 3 of frame 7:
  - Frame 7 completes with 8 frames total (seq 0-7); block then goes IDLE.
  - A further start restarts at seq 0.
- frame_len=20 and frame_len=2000: lengths clamped to 60 and 1514 respectively.
- Edge cases:
  - start+stop in the same IDLE cycle -> no tvalid.
  - start while SEND -> ignored.
  - rst mid-frame -> tvalid=0 next cycle, frames_sent=0, gen_ready=1.
